// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: registered PC, synchronous read-first instruction RAM,
// registered instruction output with valid/ready handshake and branch redirect.
module instruction_fetch_unit #(
  parameter int INS_WIDTH  = 25,
  parameter int ADDR_WIDTH = 25,
  parameter int DEPTH      = 128,
  parameter int BYTE_ADDR  = 0,
  parameter int RESET_PC   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     zero,
  input  logic                     branch,
  input  logic [INS_WIDTH-1:0]     ext,
  input  logic                     ins_ready,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [INS_WIDTH-1:0]     prog_data,
  output logic [INS_WIDTH-1:0]     ins,
  output logic [ADDR_WIDTH-1:0]    ins_pc,
  output logic                     ins_valid,
  output logic [ADDR_WIDTH-1:0]    fetch_pc,
  output logic                     busy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] STEP =
    (BYTE_ADDR != 0) ? ADDR_WIDTH'(4) : ADDR_WIDTH'(1);

  logic [INS_WIDTH-1:0]  mem [DEPTH];
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] ext_a, offset, target;
  logic [IDX_W-1:0]      rd_idx;
  logic                  taken, advance, do_fetch;

  // Offset is sign-extended or truncated to the PC width before any arithmetic.
  generate
    if (INS_WIDTH >= ADDR_WIDTH) begin : g_ext_trunc
      assign ext_a = ext[ADDR_WIDTH-1:0];
    end else begin : g_ext_sext
      assign ext_a = {{(ADDR_WIDTH-INS_WIDTH){ext[INS_WIDTH-1]}}, ext};
    end
    if (BYTE_ADDR != 0) begin : g_byte
      assign rd_idx = fetch_pc[IDX_W+1:2];
      assign offset = ext_a << 2;
    end else begin : g_word
      assign rd_idx = fetch_pc[IDX_W-1:0];
      assign offset = ext_a;
    end
  endgenerate

  assign target   = ins_pc + STEP + offset;
  assign taken    = zero & branch & ins_valid;
  assign advance  = !stall & (!ins_valid | ins_ready);
  assign do_fetch = ((state == RUN) && !taken && advance) ||
                    ((state == REDIRECT) && !stall);
  assign busy     = (state != IDLE);

  // Program-load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // The output register doubles as the RAM read register, so a same-cycle
  // write to the fetched index returns the previous word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= ADDR_WIDTH'(RESET_PC);
      ins       <= '0;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (start) state <= RUN;
        RUN: begin
          if (taken) begin
            fetch_pc  <= target;
            ins_valid <= 1'b0;
            state     <= REDIRECT;
          end
        end
        REDIRECT: if (!stall) state <= RUN;
        default:  state <= IDLE;
      endcase
      if (do_fetch) begin
        ins       <= mem[rd_idx];
        ins_pc    <= fetch_pc;
        ins_valid <= 1'b1;
        fetch_pc  <= fetch_pc + STEP;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: three instances (word/128, byte/128, word/4)
// share one stimulus stream; each is checked against its own behavioural model.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stall = 1'b0, zero = 1'b0, branch = 1'b0;
  logic        ins_ready = 1'b0, prog_we = 1'b0;
  logic [24:0] ext = '0, prog_data = '0;
  logic [6:0]  prog_addr = '0;

  logic [24:0] o_ins[3], o_ipc[3], o_fpc[3];
  logic        o_vld[3], o_busy[3];

  int tests = 0;
  int fails = 0;

  // Model state: run_st 0 = idle, 1 = fetching, 2 = bubble after redirect.
  int          byt[3] = '{0, 1, 0};
  int          dep[3] = '{128, 128, 4};
  logic [24:0] m_ins[3], m_ipc[3], m_fpc[3];
  bit          m_vld[3];
  int          run_st[3];
  logic [24:0] m_mem[3][128];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.INS_WIDTH(25), .ADDR_WIDTH(25), .DEPTH(128), .BYTE_ADDR(0), .RESET_PC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .zero(zero), .branch(branch), .ext(ext),
    .ins_ready(ins_ready), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ins(o_ins[0]), .ins_pc(o_ipc[0]), .ins_valid(o_vld[0]), .fetch_pc(o_fpc[0]), .busy(o_busy[0]));

  instruction_fetch_unit #(.INS_WIDTH(25), .ADDR_WIDTH(25), .DEPTH(128), .BYTE_ADDR(1), .RESET_PC(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .zero(zero), .branch(branch), .ext(ext),
    .ins_ready(ins_ready), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ins(o_ins[1]), .ins_pc(o_ipc[1]), .ins_valid(o_vld[1]), .fetch_pc(o_fpc[1]), .busy(o_busy[1]));

  instruction_fetch_unit #(.INS_WIDTH(25), .ADDR_WIDTH(25), .DEPTH(4), .BYTE_ADDR(0), .RESET_PC(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .zero(zero), .branch(branch), .ext(ext),
    .ins_ready(ins_ready), .prog_we(prog_we), .prog_addr(prog_addr[1:0]), .prog_data(prog_data),
    .ins(o_ins[2]), .ins_pc(o_ipc[2]), .ins_valid(o_vld[2]), .fetch_pc(o_fpc[2]), .busy(o_busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ins[k] = '0; m_ipc[k] = '0; m_fpc[k] = '0; m_vld[k] = 1'b0; run_st[k] = 0;
    end
  endtask

  task automatic model_fetch(input int k);
    int idx;
    idx = (byt[k] != 0) ? int'(m_fpc[k] / 4) % dep[k] : int'(m_fpc[k]) % dep[k];
    m_ins[k] = m_mem[k][idx];
    m_ipc[k] = m_fpc[k];
    m_vld[k] = 1'b1;
    m_fpc[k] = m_fpc[k] + ((byt[k] != 0) ? 25'd4 : 25'd1);
  endtask

  // One rising edge worth of behaviour, evaluated from the inputs seen at the edge.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit taken, adv;
      logic [24:0] unit;
      unit  = (byt[k] != 0) ? 25'd4 : 25'd1;
      taken = zero && branch && m_vld[k];
      adv   = !stall && (!m_vld[k] || ins_ready);
      if (rst) begin
        m_ins[k] = '0; m_ipc[k] = '0; m_fpc[k] = '0; m_vld[k] = 1'b0; run_st[k] = 0;
      end else if (run_st[k] == 0) begin
        if (start) run_st[k] = 1;
      end else if (run_st[k] == 1) begin
        if (taken) begin
          m_fpc[k] = m_ipc[k] + unit + ext * unit;
          m_vld[k] = 1'b0;
          run_st[k] = 2;
        end else if (adv) model_fetch(k);
      end else begin
        if (!stall) begin
          model_fetch(k);
          run_st[k] = 1;
        end
      end
      if (prog_we) m_mem[k][int'(prog_addr) % dep[k]] = prog_data;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_ins", k),   o_ins[k],  m_ins[k]);
      chk($sformatf("d%0d_ipc", k),   o_ipc[k],  m_ipc[k]);
      chk($sformatf("d%0d_vld", k),   o_vld[k],  m_vld[k]);
      chk($sformatf("d%0d_fpc", k),   o_fpc[k],  m_fpc[k]);
      chk($sformatf("d%0d_busy", k),  o_busy[k], run_st[k] != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic chk0(input string tag, input logic [24:0] e_ins, input logic [24:0] e_ipc,
                      input logic e_vld, input logic [24:0] e_fpc);
    chk({tag, "_ins"}, o_ins[0], e_ins);
    chk({tag, "_ipc"}, o_ipc[0], e_ipc);
    chk({tag, "_vld"}, o_vld[0], e_vld);
    chk({tag, "_fpc"}, o_fpc[0], e_fpc);
  endtask

  initial begin
    logic [24:0] old_word;
    #2;
    model_reset();
    check_all();
    chk0("rst0", 25'h0, 25'h0, 1'b0, 25'h0);
    chk("rst0_busy", o_busy[0], 0);
    tick();
    rst = 1'b0;

    // Program load: low words are known, the rest random.
    for (int a = 0; a < 128; a++) begin
      prog_we = 1'b1;
      prog_addr = 7'(a);
      prog_data = (a < 4) ? 25'((a + 1) * 'h11) : 25'($urandom);
      tick();
    end
    prog_we = 1'b0;

    start = 1'b1; tick();
    start = 1'b0; ins_ready = 1'b1;
    tick(); chk0("seq0", 25'h11, 25'd0, 1'b1, 25'd1);
    tick(); chk0("seq1", 25'h22, 25'd1, 1'b1, 25'd2);
    ins_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk0("bp", 25'h22, 25'd1, 1'b1, 25'd2);
    end
    ins_ready = 1'b1;
    tick(); chk0("seq2", 25'h33, 25'd2, 1'b1, 25'd3);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); chk0("stall", 25'h33, 25'd2, 1'b1, 25'd3);
    end
    stall = 1'b0;
    tick(); chk0("seq3", 25'h44, 25'd3, 1'b1, 25'd4);
    tick(); tick();
    chk("pc5", o_ipc[0], 25'd5);

    // Taken branch at pc 5, offset -3: target 3 after one bubble.
    zero = 1'b1; branch = 1'b1; ext = -25'sd3;
    tick(); chk("br_vld", o_vld[0], 0); chk("br_fpc", o_fpc[0], 25'd3);
    zero = 1'b0; branch = 1'b0;
    tick(); chk0("br_tgt", 25'h44, 25'd3, 1'b1, 25'd4);
    tick(); tick();
    // Not-taken branch just falls through.
    branch = 1'b1;
    tick(); chk("nt_ipc", o_ipc[0], 25'd6); chk("nt_vld", o_vld[0], 1);
    branch = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pc10", o_ipc[0], 25'd10);

    // Branch wins over stall and backpressure; bubble persists while stalled.
    stall = 1'b1; ins_ready = 1'b0; zero = 1'b1; branch = 1'b1; ext = 25'd2;
    tick(); chk("bs_vld", o_vld[0], 0); chk("bs_fpc", o_fpc[0], 25'd13);
    zero = 1'b0; branch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); chk("bs_hold_vld", o_vld[0], 0); chk("bs_hold_fpc", o_fpc[0], 25'd13);
      chk("bs_busy", o_busy[0], 1);
    end
    stall = 1'b0; ins_ready = 1'b1;
    tick(); chk("bs_ipc", o_ipc[0], 25'd13); chk("bs_vld2", o_vld[0], 1);

    // Write the index being fetched this cycle: the old word comes out.
    old_word = m_mem[0][14];
    prog_we = 1'b1; prog_addr = 7'd14; prog_data = ~old_word;
    tick(); chk("rf_ins", o_ins[0], old_word); chk("rf_ipc", o_ipc[0], 25'd14);
    prog_we = 1'b0;

    // Reset mid-run takes effect without waiting for an edge.
    #2 rst = 1'b1; #1;
    model_reset();
    check_all();
    chk0("rst1", 25'h0, 25'h0, 1'b0, 25'h0);
    tick();
    rst = 1'b0;

    // Randomised traffic with occasional redirects, loads and resets.
    for (int n = 0; n < 1500; n++) begin
      start     = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      ins_ready = ($urandom_range(0, 3) != 0);
      branch    = ($urandom_range(0, 5) == 0);
      zero      = $urandom_range(0, 1) == 1;
      ext       = 25'($signed($urandom_range(0, 15)) - 8);
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 7'($urandom);
      prog_data = 25'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; #1;
        model_reset();
        check_all();
      end
      tick();
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
